alu_driver: RTL

Execute-stage sequencer that issues one operation at a time to the one-cycle-latency `alu` and returns its result to writeback. It accepts decoded requests on a valid/ready interface, registers and presents operands with `o_alu_valid`, waits for the ALU's `i_alu_valid`, and holds the result until writeback accepts it. It also provides a timeout with error flag and a pipeline flush.

---
 rtl/alu_driver_if.sv | 40 ++++
 rtl/alu_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_driver_if.sv
// Bus bundle between the execute-stage driver, its ALU and writeback.
// The driver side uses the slave modport; the environment uses master.
interface alu_driver_if;
  // request from decode
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_req_op;
  logic [31:0] i_req_a;
  logic [31:0] i_req_b;
  logic [4:0]  i_req_rd;

  // ALU issue and return
  logic [3:0]  o_alu_op;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic        o_alu_valid;
  logic [31:0] i_alu_out;
  logic        i_alu_valid;

  // writeback
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_err;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_req_rd,
    input  i_alu_out, i_alu_valid, i_wb_ready,
    output o_req_ready, o_alu_op, o_alu_a, o_alu_b, o_alu_valid,
    output o_wb_valid, o_wb_data, o_wb_rd, o_wb_err
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_req_rd,
    output i_alu_out, i_alu_valid, i_wb_ready,
    input  o_req_ready, o_alu_op, o_alu_a, o_alu_b, o_alu_valid,
    input  o_wb_valid, o_wb_data, o_wb_rd, o_wb_err
  );
endinterface

// File: rtl/alu_driver.sv
// Execute-stage sequencer: issues one op to a one-cycle ALU, waits for its
// result (or a timeout), and holds the completion until writeback takes it.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | no op in flight, ready for a request
//   S_ISSUE | operands presented to the ALU with o_alu_valid for one cycle
//   S_WAIT  | operands held, sampling i_alu_valid, counting toward timeout
//   S_DONE  | completion held on o_wb_* until i_wb_ready
module alu_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  alu_driver_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             req_ready;
  logic             alu_valid;
  logic             wb_valid;
  logic             accept;
  logic             timed_out;

  logic [CNT_W-1:0] wait_cnt_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [4:0]       rd_q;
  logic [31:0]      data_q;
  logic             err_q;

  assign accept    = req_ready & bus.i_req_valid;
  assign timed_out = ~bus.i_alu_valid & (wait_cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_d = S_ISSUE;
        end
        S_ISSUE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_alu_valid || timed_out) state_d = S_DONE;
        end
        S_DONE: begin
          if (bus.i_wb_ready) state_d = accept ? S_ISSUE : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // outputs decoded from state; ready never looks at the request itself
  always_comb begin
    req_ready = 1'b0;
    alu_valid = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = ~i_flush;
      end
      S_ISSUE: begin
        alu_valid = 1'b1;
      end
      S_DONE: begin
        wb_valid  = 1'b1;
        req_ready = ~i_flush & bus.i_wb_ready;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // request capture; accept already excludes flush
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= bus.i_req_op;
      a_q  <= bus.i_req_a;
      b_q  <= bus.i_req_b;
      rd_q <= bus.i_req_rd;
    end
  end

  // wait counter: zeroed while issuing so WAIT always starts from 0; saturates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
    end else if (i_flush || state_q == S_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT && !bus.i_alu_valid && wait_cnt_q != CNT_LAST) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // completion capture: ALU result, or zero data with the error flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (i_flush) begin
      err_q  <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.i_alu_valid) begin
        data_q <= bus.i_alu_out;
        err_q  <= 1'b0;
      end else if (timed_out) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_alu_valid = alu_valid;
  assign bus.o_alu_op    = op_q;
  assign bus.o_alu_a     = a_q;
  assign bus.o_alu_b     = b_q;
  assign bus.o_wb_valid  = wb_valid;
  assign bus.o_wb_data   = data_q;
  assign bus.o_wb_rd     = rd_q;
  assign bus.o_wb_err    = err_q;

endmodule
